// File: rtl/rf_dbg_dumper_pkg.sv
// Shared types and default sizes for the register-file debug dumper.
// Imported by the dumper and by RF/PDU blocks that agree on NREG/AW.
package rf_dbg_dumper_pkg;

   localparam int unsigned NREG_DEF = 32;
   localparam int unsigned AW_DEF   = 5;
   localparam int unsigned DW_DEF   = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      SEND = 2'd2,
      FIN  = 2'd3
   } state_t;

endpackage

// File: rtl/rf_dbg_dumper_if.sv
// Valid/ready beat stream carrying {index, value, last} out of the dumper.
interface rf_dbg_dumper_if #(
   parameter int unsigned AW = 5,
   parameter int unsigned DW = 32
);
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_idx;
   logic [DW-1:0] out_data;
   logic          out_last;

   modport master (output out_valid, output out_idx, output out_data, output out_last,
                   input  out_ready);
   modport slave  (input  out_valid, input  out_idx, input  out_data, input  out_last,
                   output out_ready);
endinterface

// File: rtl/rf_dbg_dumper.sv
// Walks the RF debug read port and streams {index, value} beats over valid/ready.
// Optional RF_DUMP_SKIP_ZERO_EN: zero-valued registers (except the last) emit no beat.
module rf_dbg_dumper
   import rf_dbg_dumper_pkg::*;
#(
   parameter int unsigned NREG      = NREG_DEF,
   parameter int unsigned AW        = AW_DEF,
   parameter int unsigned DW        = DW_DEF,
   parameter int unsigned FIRST_IDX = 0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   output logic [AW-1:0]    ra_dbg,
   input  logic [DW-1:0]    rd_dbg,
   rf_dbg_dumper_if.master  o_dump,
   output logic             busy,
   output logic             done
);

   localparam logic [AW-1:0] LAST_IDX  = AW'(NREG - 1);
   localparam logic [AW-1:0] FIRST_ADR = AW'(FIRST_IDX);

   state_t r_state;
   logic   w_is_last;
   logic   w_hs;
   logic   w_skip;

   assign w_is_last = (ra_dbg == LAST_IDX);
   assign w_hs      = o_dump.out_valid && o_dump.out_ready;

`ifdef RF_DUMP_SKIP_ZERO_EN
   assign w_skip = (rd_dbg == '0) && !w_is_last;
`else
   assign w_skip = 1'b0;
`endif

   // Scan FSM; out_* stay frozen in SEND until the sink takes the beat.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state         <= IDLE;
         ra_dbg          <= '0;
         o_dump.out_valid <= 1'b0;
         o_dump.out_idx   <= '0;
         o_dump.out_data  <= '0;
         o_dump.out_last  <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  ra_dbg  <= FIRST_ADR;
                  busy    <= 1'b1;
                  r_state <= RD;
               end
            end
            RD: begin
               if (w_skip) begin
                  ra_dbg <= ra_dbg + AW'(1);
               end else begin
                  o_dump.out_data  <= rd_dbg;
                  o_dump.out_idx   <= ra_dbg;
                  o_dump.out_last  <= w_is_last;
                  o_dump.out_valid <= 1'b1;
                  r_state          <= SEND;
               end
            end
            SEND: begin
               if (w_hs) begin
                  o_dump.out_valid <= 1'b0;
                  if (o_dump.out_last) begin
                     r_state <= FIN;
                  end else begin
                     ra_dbg  <= ra_dbg + AW'(1);
                     r_state <= RD;
                  end
               end
            end
            FIN: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rf_dbg_dumper.sv
// Directed bench for rf_dbg_dumper with a small write-first RF model on the debug port.
`timescale 1ns/1ps
module tb_rf_dbg_dumper;

   localparam int NREG  = 32;
   localparam int FIRST = 0;
`ifdef RF_DUMP_SKIP_ZERO_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic        clk;
   logic        rstn;
   logic        start;
   logic [4:0]  ra_dbg;
   logic [31:0] rd_dbg;
   logic        busy;
   logic        done;

   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic        x7_w;
   logic [31:0] x7_v;
   bit          x7_exp;

   int n_assert;
   int n_fail;

   rf_dbg_dumper_if #(.AW(5), .DW(32)) dump_if ();

   rf_dbg_dumper #(.NREG(32), .AW(5), .DW(32), .FIRST_IDX(0)) dut (
      .clk    (clk),
      .rstn   (rstn),
      .start  (start),
      .ra_dbg (ra_dbg),
      .rd_dbg (rd_dbg),
      .o_dump (dump_if),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] base_val(input int k);
      if (k == 2) return 32'h2ffc;
      if (k == 3) return 32'h1800;
      if (SKIP)   return 32'h0;
      return 32'(k * 4);
   endfunction

   function automatic logic [31:0] exp_val(input int k);
      if (k == 0) return 32'h0;
      if (k == 7 && x7_exp) return 32'hdeadbeef;
      return base_val(k);
   endfunction

   // Only x7 is ever written by the bench; x0 writes are discarded.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         x7_w <= 1'b0;
         x7_v <= '0;
      end else if (we && wa == 5'd7) begin
         x7_w <= 1'b1;
         x7_v <= wd;
      end
   end

   always_comb begin
      rd_dbg = base_val(int'(ra_dbg));
      if (ra_dbg == 5'd0)                 rd_dbg = '0;
      else if (we && wa == ra_dbg)        rd_dbg = wd;
      else if (ra_dbg == 5'd7 && x7_w)    rd_dbg = x7_v;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_dump(input int pct, input bit bypass, input bit spam, input int exp_done);
      int          q[$];
      int          n;
      bit          pv, pr, fin;
      logic [4:0]  pi;
      logic [31:0] pd;
      logic        pl;
      for (int k = FIRST; k < NREG; k++)
         if (!SKIP || exp_val(k) != 0 || k == NREG - 1) q.push_back(k);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_busy",  64'(busy), 64'd1);
      chk("start_ra",    64'(ra_dbg), 64'(FIRST));
      chk("start_valid", 64'(dump_if.out_valid), 64'd0);
      pv = 0; pr = 0; fin = 0; n = 0; pi = '0; pd = '0; pl = 1'b0;
      dump_if.out_ready = 1'b1;
      for (int cyc = 1; cyc <= 3000 && !fin; cyc++) begin
         @(posedge clk); #1;
         if (pv && pr) begin
            if (n < q.size()) begin
               chk("beat_idx",  64'(pi), 64'(q[n]));
               chk("beat_data", 64'(pd), 64'(exp_val(q[n])));
               chk("beat_last", 64'(pl), 64'(q[n] == NREG - 1));
            end else begin
               chk("extra_beat", 64'd1, 64'd0);
            end
            n++;
         end else if (pv) begin
            chk("hold_valid", 64'(dump_if.out_valid), 64'd1);
            chk("hold_idx",   64'(dump_if.out_idx),   64'(pi));
            chk("hold_data",  64'(dump_if.out_data),  64'(pd));
            chk("hold_last",  64'(dump_if.out_last),  64'(pl));
         end
         if (done) begin
            chk("beat_count", 64'(n), 64'(q.size()));
            chk("busy_at_done", 64'(busy), 64'd0);
            if (exp_done > 0) chk("done_cycle", 64'(cyc), 64'(exp_done));
            fin = 1;
         end
         dump_if.out_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < 32'(pct));
         pv = dump_if.out_valid;
         pr = dump_if.out_ready;
         pi = dump_if.out_idx;
         pd = dump_if.out_data;
         pl = dump_if.out_last;
         start = spam && busy;
         we = 1'b0; wa = '0; wd = '0;
         if (bypass && busy && !dump_if.out_valid && ra_dbg == 5'd7) begin
            we = 1'b1; wa = 5'd7; wd = 32'hdeadbeef;
         end else if (bypass && busy && ra_dbg == 5'd3) begin
            we = 1'b1; wa = 5'd0; wd = 32'hcafef00d;
         end
      end
      if (!fin) chk("done_timeout", 64'd0, 64'd1);
      start = 1'b0; we = 1'b0;
      dump_if.out_ready = 1'b1;
   endtask

   initial begin
      clk = 1'b0; rstn = 1'b0; start = 1'b0;
      we = 1'b0; wa = '0; wd = '0; x7_exp = 1'b0;
      n_assert = 0; n_fail = 0;
      dump_if.out_ready = 1'b1;
      #1;
      chk("rst_valid", 64'(dump_if.out_valid), 64'd0);
      chk("rst_busy",  64'(busy), 64'd0);
      chk("rst_ra",    64'(ra_dbg), 64'd0);
      repeat (3) @(posedge clk);
      @(negedge clk); rstn = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Abort mid-dump: outputs clear asynchronously and stay quiet afterwards.
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (11) @(posedge clk);
      #2;
      chk("mid_busy", 64'(busy), 64'd1);
`ifndef RF_DUMP_SKIP_ZERO_EN
      chk("mid_valid", 64'(dump_if.out_valid), 64'd1);
      chk("mid_idx",   64'(dump_if.out_idx), 64'd5);
`endif
      rstn = 1'b0;
      #1;
      chk("arst_ra",    64'(ra_dbg), 64'd0);
      chk("arst_valid", 64'(dump_if.out_valid), 64'd0);
      chk("arst_idx",   64'(dump_if.out_idx), 64'd0);
      chk("arst_data",  64'(dump_if.out_data), 64'd0);
      chk("arst_last",  64'(dump_if.out_last), 64'd0);
      chk("arst_busy",  64'(busy), 64'd0);
      chk("arst_done",  64'(done), 64'd0);
      @(negedge clk); rstn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         chk("post_rst_valid", 64'(dump_if.out_valid), 64'd0);
         chk("post_rst_busy",  64'(busy), 64'd0);
      end

      // Full dump with the sink always ready.
      run_dump(100, 1'b0, 1'b0, SKIP ? 0 : 2 * NREG + 1);
      repeat (3) @(posedge clk);
      #1;

      // Random backpressure.
      run_dump(30, 1'b0, 1'b0, 0);
      repeat (3) @(posedge clk);
      #1;

      // Start spam while busy and on the FIN cycle must not restart the scan.
      run_dump(100, 1'b0, 1'b1, SKIP ? 0 : 2 * NREG + 1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("spam_no_restart", 64'(busy), 64'd0);
         chk("spam_no_done",    64'(done), 64'd0);
      end

      // Write-first bypass on x7, ignored writes to x0.
      x7_exp = 1'b1;
      run_dump(100, 1'b1, 1'b0, 0);
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
